// File: rtl/pipe_addsub_if.sv
// Operand/result stream bundle for pipe_addsub: valid/ready operand side and
// valid/ready result side.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into SEG
// registered chunks, one chunk resolved per stage, with a single global stall.
module pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int unsigned CW = WIDTH / SEG;

    logic w_en;

    for (genvar k = 0; k < SEG; k++) begin : g_stage
        // IW: operand bits not yet summed on entry; DW: result bits known on exit
        localparam int unsigned IW = WIDTH - k * CW;
        localparam int unsigned DW = (k + 1) * CW;

        logic [IW-1:0] w_op_a;
        logic [IW-1:0] w_op_b;
        logic          w_c_in;
        logic          w_v_in;
        logic [CW:0]   w_chunk;
        logic [DW-1:0] w_sum;

        logic          r_valid;
        logic          r_c;
        logic [DW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_op_a = bus.a;
            assign w_op_b = bus.b ^ {WIDTH{bus.sub}};
            assign w_c_in = bus.cin ^ bus.sub;
            assign w_v_in = bus.in_valid;
            assign w_sum  = w_chunk[CW-1:0];
        end else begin : g_src
            assign w_op_a = g_stage[k-1].g_rest.r_a;
            assign w_op_b = g_stage[k-1].g_rest.r_b;
            assign w_c_in = g_stage[k-1].r_c;
            assign w_v_in = g_stage[k-1].r_valid;
            assign w_sum  = {w_chunk[CW-1:0], g_stage[k-1].r_sum};
        end

        assign w_chunk = {1'b0, w_op_a[CW-1:0]} + {1'b0, w_op_b[CW-1:0]}
                       + {{CW{1'b0}}, w_c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_v_in;
                r_c     <= w_chunk[CW];
                r_sum   <= w_sum;
            end
        end

        if (k < SEG - 1) begin : g_rest
            logic [IW-CW-1:0] r_a;
            logic [IW-CW-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_op_a[IW-1:CW];
                    r_b <= w_op_b[IW-1:CW];
                end
            end
        end else begin : g_tail
            logic w_c_msb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB's own sum bit and operands.
            assign w_c_msb = w_op_a[IW-1] ^ w_op_b[IW-1] ^ w_chunk[CW-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= w_c_msb ^ w_chunk[CW];
                end
            end
        end
    end

    assign w_en          = ~g_stage[SEG-1].r_valid | bus.out_ready;
    assign bus.in_ready  = w_en & ~rst;
    assign bus.out_valid = g_stage[SEG-1].r_valid;
    assign bus.s         = g_stage[SEG-1].r_sum;
    assign bus.cout      = g_stage[SEG-1].r_c;
    assign bus.ovf       = g_stage[SEG-1].g_tail.r_ovf;
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. Generalises the team's 16-bit ripple-carry adder:
- configurable operand width;
- carry chain split into registered segments for timing closure;
- per-transaction add/subtract select and signed-overflow flag;
- full-throughput streaming with backpressure.

It sits in the datapath between operand sources and any consumer that can stall.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG and ≥ SEG.
- SEG, 4, number of pipeline segments (chunks of WIDTH/SEG bits, one per stage); ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  result.
- cout  output  1  carry-out of MSB; for subtract, 1 means no borrow.
- ovf  output  1  signed overflow.

## Operation
Operand transform at acceptance:
- B' = b XOR {WIDTH{sub}}.
- Carry-in c0 = cin XOR sub.
- Add: A + B + cin. Subtract: A − B − cin.

Pipeline structure:
- Stage k (1..SEG) register holds: valid bit; result chunks 0..k−1; unprocessed chunks of A and B'; carry into chunk k; and, at the last stage, carry into the MSB.
- Stage 1 computes chunk 0 from the input ports and c0.
- Stage k+1 computes chunk k from stage-k operands and stage-k carry.
- Each chunk is a ripple sum of WIDTH/SEG bits.

Outputs:
- s, cout, out_valid are driven directly from the stage-SEG register.
- ovf = (carry into bit WIDTH−1) XOR cout, registered with the final stage.

Flow control:
- Global enable en = !out_valid | out_ready.
- in_ready = en & !rst.
- When en = 1, every stage register loads from its predecessor (stage 1 loads from the ports, with valid = in_valid).
- When en = 0, all stages hold.
- Bubbles (invalid stages) advance like data. Data bits of invalid stages are don't-care, but s/cout/ovf must be stable while out_valid = 1 and out_ready = 0.

Transfers:
- Input transfer occurs on in_valid & in_ready at a rising edge.
- Output transfer occurs on out_valid & out_ready.
- in_valid/a/b/cin/sub may change freely when no transfer occurs.
- Results emerge strictly in acceptance order. Nothing is dropped or duplicated.

## Timing
Reset:
- While rst is high at a rising edge, all valid bits clear and s = 0, cout = 0, ovf = 0, out_valid = 0.
- in_ready = 0 combinationally while rst = 1.
- Reset mid-operation discards all in-flight transactions, with no partial output.
- The first acceptance is possible on the first edge with rst = 0.

Latency:
- A transaction accepted at edge T is presented with out_valid = 1 after edge T+SEG−1 (SEG edges including the accepting edge), provided no stall intervenes.
- Each stall cycle (en = 0) adds one cycle.
- SEG = 1 gives a fully registered single-cycle adder.

Throughput: one transaction per cycle while out_ready = 1.

Simultaneous events:
- Output transfer and input acceptance in the same cycle are legal; the pipeline shifts.
- With out_valid = 1 and out_ready = 0, in_ready = 0 and the pipeline holds, even if earlier stages contain bubbles. No bubble compression.

Wrap-around: results are modulo 2^WIDTH; the carry/borrow is reported only on cout.

## Test plan
Test plan, with WIDTH=16 and SEG=4 unless noted:
- **Add with carry-out:** reset 2 cycles, then a=0xFFFF, b=0x0001, cin=0, sub=0 → exactly 4 cycles later s=0x0000, cout=1, ovf=0. Before reset release, out_valid=0 and s=0.
- **Signed overflow and cin:** a=0x7FFF, b=0x0000, cin=1, sub=0 → s=0x8000, cout=0, ovf=1. Then sub=1, a=0x8000, b=0x0001, cin=0 → s=0x7FFF, cout=1, ovf=1.
- **Subtract with borrow:** a=0x0005, b=0x0007, sub=1, cin=0 → s=0xFFFE, cout=0, ovf=0. Then a=0x1234, b=0x1234, sub=1 → s=0x0000, cout=1.
- **Streaming:** 100 back-to-back random transactions with out_ready=1 → one result per cycle after 4-cycle fill, in order, all matching a golden model; repeat with SEG=1 and SEG=16.
- **Backpressure:** hold out_ready=0 for 3 cycles while a result is valid → s/cout/ovf/out_valid stable, in_ready=0, no acceptance. Release → remaining results drain in order, no loss or duplication. Randomised out_ready/in_valid soak of 10k transactions, scoreboard clean.
- **Reset mid-stream:** 3 transactions in flight, assert rst for 1 cycle → next cycle out_valid=0, s=0. None of the 3 ever appear. A new transaction accepted immediately after reset emerges with normal 4-cycle latency.
